pipelined_mux_sel_seq: RTL

Parametrised, registered N:1 multiplexer with a built-in channel sequencer. It generalises the combinational 8:1 selector to configurable width and channel count. Channel selection comes from two sources: an external select with valid/ready handshake, or an internal round-robin scan mode. It sits between a bank of parallel data sources and a single downstream consumer in the lab's datapath exercises.

---
 rtl/pipelined_mux_sel_seq.sv | 72 +++++++
 1 files changed

// File: rtl/pipelined_mux_sel_seq.sv
// rtl/pipelined_mux_sel_seq.sv - registered N:1 channel mux with external-select or round-robin scan sequencing
module pipelined_mux_sel_seq #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic                 mode,
    input  logic [SELW-1:0]      S,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     Y,
    output logic [SELW-1:0]      y_chan,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 scan_wrap
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t          state;
    logic [SELW-1:0] idx;
    logic [SELW-1:0] sel;
    logic            fire;

    // The output register can take a new beat when empty or being drained this cycle.
    assign s_ready = !y_valid || y_ready;
    assign fire    = mode ? s_ready : (s_valid && s_ready);
    assign sel     = mode ? idx : S;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Y         <= '0;
            y_chan    <= '0;
            y_valid   <= 1'b0;
            scan_wrap <= 1'b0;
            idx       <= '0;
        end else begin
            scan_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        state   <= HOLD;
                        y_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (y_ready && !fire) begin
                        state   <= IDLE;
                        y_valid <= 1'b0;
                    end
                end
            endcase
            if (fire) begin
                Y      <= D[sel*WIDTH +: WIDTH];
                y_chan <= sel;
                // idx only moves on an accepted scan beat, so a stall never skips a channel.
                if (mode) begin
                    idx       <= idx + 1'b1;
                    scan_wrap <= (idx == SELW'(NCH - 1));
                end
            end
        end
    end

endmodule
